// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared widths, RAM map and FSM state encoding for score tracking
package score_pkg;

  localparam int SCORE_W     = 7;
  localparam int ADDR_W      = 5;
  localparam int GLOBAL_ADDR = 8;
  localparam int CLEAR_WORDS = 32;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    RD_P  = 3'd2,
    CMP_P = 3'd3,
    RD_G  = 3'd4,
    CMP_G = 3'd5,
    DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/ram_score.sv
// rtl/ram_score.sv - 32x7 score RAM, synchronous write and registered read
module ram_score #(
  parameter int DATA_W = score_pkg::SCORE_W,
  parameter int ADDR_W = score_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read returns the old word on a same-address write (read-before-write).
  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/score_tracking.sv
// rtl/score_tracking.sv - personal/global best-score tracker driving an external score RAM
// Optional RAM clear after reset: SCORE_CLEAR_ON_RESET_EN
module score_tracking #(
  parameter int SCORE_W     = score_pkg::SCORE_W,
  parameter int ADDR_W      = score_pkg::ADDR_W,
  parameter int GLOBAL_ADDR = score_pkg::GLOBAL_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score,
  input  logic [2:0]         playerID,
  input  logic               isGuest,
  input  logic [SCORE_W-1:0] RAM_data,
  output logic               personal_winner,
  output logic               global_winner,
  output logic [ADDR_W-1:0]  RAM_addr,
  output logic [SCORE_W-1:0] RAM_out,
  output logic               RAM_W,
  output logic               RAM_R,
  output logic               valid
);
  import score_pkg::*;

`ifdef SCORE_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e             state;
  state_e             state_nxt;
  logic               req_q;
  logic               req_rise;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         pid_q;
  logic               guest_q;
  logic [ADDR_W-1:0]  clr_cnt;
  logic               win;

  assign req_rise = score_req & ~req_q;
  assign win      = score_q > RAM_data;

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef SCORE_CLEAR_ON_RESET_EN
      INIT:    if (clr_cnt == ADDR_W'(CLEAR_WORDS - 1)) state_nxt = IDLE;
`endif
      IDLE:    if (req_rise) state_nxt = isGuest ? RD_G : RD_P;
      RD_P:    state_nxt = CMP_P;
      CMP_P:   state_nxt = RD_G;
      RD_G:    state_nxt = CMP_G;
      CMP_G:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RESET_STATE;
      req_q           <= 1'b0;
      score_q         <= '0;
      pid_q           <= '0;
      guest_q         <= 1'b0;
      clr_cnt         <= '0;
      personal_winner <= 1'b0;
      global_winner   <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= score_req;
      if (state == IDLE && req_rise) begin
        score_q <= score;
        pid_q   <= playerID;
        guest_q <= isGuest;
        // Guests skip the personal phase, so the flag is settled here.
        if (isGuest) personal_winner <= 1'b0;
      end
      if (state == INIT)  clr_cnt         <= clr_cnt + 1'b1;
      if (state == CMP_P) personal_winner <= win & ~guest_q;
      if (state == CMP_G) global_winner   <= win;
    end
  end

  // RAM strobes are gated by rst so nothing reaches the RAM while reset is held.
  always_comb begin
    RAM_addr = '0;
    RAM_out  = '0;
    RAM_W    = 1'b0;
    RAM_R    = 1'b0;
    if (rst) begin
      case (state)
        INIT: begin
          RAM_addr = clr_cnt;
          RAM_W    = 1'b1;
        end
        RD_P: begin
          RAM_addr = ADDR_W'(pid_q);
          RAM_R    = 1'b1;
        end
        CMP_P: begin
          RAM_addr = ADDR_W'(pid_q);
          if (win && !guest_q) begin
            RAM_W   = 1'b1;
            RAM_out = score_q;
          end
        end
        RD_G: begin
          RAM_addr = ADDR_W'(GLOBAL_ADDR);
          RAM_R    = 1'b1;
        end
        CMP_G: begin
          RAM_addr = ADDR_W'(GLOBAL_ADDR);
          if (win) begin
            RAM_W   = 1'b1;
            RAM_out = score_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = rst & (state == DONE);

endmodule

// File: tb/tb_score_tracking.sv
// tb/tb_score_tracking.sv - scoreboard bench for score_tracking with a behavioural RAM and best-score model
module tb_score_tracking;

  localparam int SW = 7;
  localparam int AW = 5;
  localparam int GA = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          score_req = 1'b0;
  logic [SW-1:0] score = '0;
  logic [2:0]    playerID = '0;
  logic          isGuest = 1'b0;
  logic [SW-1:0] RAM_data;
  logic          personal_winner, global_winner, RAM_W, RAM_R, valid;
  logic [AW-1:0] RAM_addr;
  logic [SW-1:0] RAM_out;

  always #5 clk = ~clk;

  score_tracking #(.SCORE_W(SW), .ADDR_W(AW), .GLOBAL_ADDR(GA)) dut (
    .clk(clk), .rst(rst), .score_req(score_req), .score(score), .playerID(playerID),
    .isGuest(isGuest), .RAM_data(RAM_data), .personal_winner(personal_winner),
    .global_winner(global_winner), .RAM_addr(RAM_addr), .RAM_out(RAM_out),
    .RAM_W(RAM_W), .RAM_R(RAM_R), .valid(valid)
  );

  // Behavioural RAM with one-cycle registered read
  logic          mem_clear = 1'b1;
  logic [SW-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      RAM_data <= '0;
    end else begin
      if (RAM_W) mem[RAM_addr] <= RAM_out;
      if (RAM_R) RAM_data <= mem[RAM_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int best [32];
  int done_cnt = 0;

  typedef struct {
    logic pw;
    logic gw;
    int   lat;
    int   start;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ram_mismatches();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (mem[i] !== best[i][SW-1:0]) n++;
    return n;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT pulses valid
  initial begin
    exp_t e;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_valid) check("valid_width", valid, 0);
      prev_valid = valid;
      if (valid) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("personal_winner", personal_winner, e.pw);
          check("global_winner", global_winner, e.gw);
          check("latency", cyc - e.start, e.lat);
          check("ram_contents", ram_mismatches(), 0);
        end
        done_cnt++;
      end
    end
  end

  task automatic check_reset_outputs();
    check("reset_outputs", {personal_winner, global_winner, valid, RAM_W, RAM_R, RAM_addr, RAM_out}, 0);
  endtask

  task automatic after_reset_release();
`ifdef SCORE_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) best[i] = 0;
    repeat (34) @(negedge clk);
`else
    @(negedge clk);
`endif
  endtask

  task automatic do_req(input int pid, input int sc, input logic guest, input int hold);
    exp_t e;
    int   target;
    int   budget;
    target = done_cnt + 1;
    @(negedge clk);
    playerID = 3'(pid); score = SW'(sc); isGuest = guest; score_req = 1'b1;
    e.pw = 1'b0;
    if (!guest && sc > best[pid]) begin
      e.pw = 1'b1;
      best[pid] = sc;
    end
    e.gw = 1'b0;
    if (sc > best[GA]) begin
      e.gw = 1'b1;
      best[GA] = sc;
    end
    e.lat = guest ? 2 : 4;
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs after sampling; the DUT must work from its latched copy.
    score = SW'($urandom); playerID = 3'($urandom); isGuest = 1'($urandom);
    for (int i = 1; i < hold; i++) @(negedge clk);
    score_req = 1'b0;
    budget = 20;
    while (done_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid expected one within 20 cycles");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    check("idle_strobes", {RAM_W, RAM_R, valid}, 0);
  endtask

  task automatic do_abort(input int pid, input int sc, input int depth);
    @(negedge clk);
    playerID = 3'(pid); score = SW'(sc); isGuest = 1'b0; score_req = 1'b1;
    repeat (depth) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    // The personal write lands before the global phase begins.
    if (depth >= 3 && sc > best[pid]) best[pid] = sc;
    score_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    after_reset_release();
    check("abort_flags", {personal_winner, global_winner}, 0);
    check("abort_ram", ram_mismatches(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) best[i] = 0;
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
`ifdef SCORE_CLEAR_ON_RESET_EN
    begin
      int wcnt = 0;
      repeat (34) begin
        @(negedge clk);
        if (RAM_W && RAM_out == '0) wcnt++;
      end
      check("init_clear_writes", wcnt, 32);
    end
`else
    @(negedge clk);
`endif
    do_req(5, 7, 1'b0, 1);
    do_req(5, 5, 1'b0, 2);
    do_req(5, 9, 1'b0, 8);
    do_req(1, 8, 1'b0, 1);
    do_req(5, 10, 1'b1, 3);
    do_abort(1, 8, 2);
    do_abort(2, 100, 2);
    do_abort(3, 90, 4);
    do_req(1, 8, 1'b0, 1);
    for (int i = 0; i < 40; i++) begin
      int lim;
      lim = (20 + i * 3 > 127) ? 127 : 20 + i * 3;
      do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, lim)),
             ($urandom_range(0, 3) == 0), int'($urandom_range(1, 6)));
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

endmodule
